// File: rtl/mux2_reg.sv
// mux2_reg: 2:1 datapath mux with a combinational output and a registered,
// valid-flagged copy for pipelined consumers.
module mux2_reg #(
  parameter int unsigned WIDTH     = 1,
  parameter logic [63:0] RESET_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             q_sel
);

  // RESET_VAL is truncated to the data width.
  localparam logic [WIDTH-1:0] RESET_Q = RESET_VAL[WIDTH-1:0];

  // Pure bitwise select; no latching, independent of clk/reset/en.
  always_comb begin
    f = sel ? b : a;
  end

  // Registered copy: reset clears, en captures the current select, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= RESET_Q;
      q_sel   <= 1'b0;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= f;
      q_sel   <= sel;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux2_reg.sv
// Testbench for mux2_reg: literal directed checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_mux2_reg;

  localparam int unsigned W8 = 8;
  localparam logic [63:0] RV8 = 64'h3C;

  logic clk = 1'b0;
  logic reset;
  logic [W8-1:0] a8, b8, f8, q8;
  logic sel8, en8, qv8, qs8;

  logic a1, b1, s1, f1, q1, qv1, qs1;
  logic [31:0] a32, b32, f32, q32;
  logic s32, qv32, qs32;

  int checks = 0;
  int errors = 0;

  // Model state: what the registered path must hold.
  logic          m_known = 1'b0;
  logic [W8-1:0] m_q;
  logic          m_sel;
  logic          m_valid;

  always #5 clk = ~clk;

  mux2_reg #(.WIDTH(W8), .RESET_VAL(RV8)) dut8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8), .sel(sel8), .en(en8),
    .f(f8), .q(q8), .q_valid(qv8), .q_sel(qs8)
  );

  mux2_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .sel(s1), .en(1'b0),
    .f(f1), .q(q1), .q_valid(qv1), .q_sel(qs1)
  );

  mux2_reg #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .a(a32), .b(b32), .sel(s32), .en(1'b0),
    .f(f32), .q(q32), .q_valid(qv32), .q_sel(qs32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: the last value selected on an enabled edge since reset.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_known = 1'b1;
      m_q     = RV8[W8-1:0];
      m_sel   = 1'b0;
      m_valid = 1'b0;
    end else if (m_known && en8 === 1'b1) begin
      m_q     = (sel8 == 1'b1) ? b8 : a8;
      m_sel   = sel8;
      m_valid = 1'b1;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("f8", 64'(f8), 64'((sel8 == 1'b1) ? b8 : a8));
    if (m_known) begin
      check("q8", 64'(q8), 64'(m_q));
      check("q_sel8", 64'(qs8), 64'(m_sel));
      check("q_valid8", 64'(qv8), 64'(m_valid));
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] f1_tab;
    logic [2:0] idx;
    f1_tab = 8'b11011000;

    reset = 1'b1; en8 = 1'b0; sel8 = 1'b0; a8 = '0; b8 = '0;
    a1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
    a32 = '0; b32 = '0; s32 = 1'b0;

    // WIDTH=1 exhaustive combinational table, (a,b,sel) order.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      {a1, b1, s1} = idx;
      #1;
      check("f1_table", 64'(f1), 64'(f1_tab[idx]));
      #4;
    end

    // WIDTH=32 select with no clock edge required.
    a32 = 32'hDEADBEEF; b32 = 32'h12345678; s32 = 1'b0;
    #1 check("f32_sel0", 64'(f32), 64'hDEADBEEF);
    s32 = 1'b1;
    #1 check("f32_sel1", 64'(f32), 64'h12345678);

    // Reset state.
    edge1(); edge1();
    check("rst_q", 64'(q8), 64'h3C);
    check("rst_valid", 64'(qv8), 64'd0);
    check("rst_qsel", 64'(qs8), 64'd0);

    // Registered capture of b, then hold while inputs move.
    reset = 1'b0; en8 = 1'b1; sel8 = 1'b1; b8 = 8'hA5; a8 = 8'h11;
    edge1();
    check("cap_q", 64'(q8), 64'hA5);
    check("cap_qsel", 64'(qs8), 64'd1);
    check("cap_valid", 64'(qv8), 64'd1);
    en8 = 1'b0; sel8 = 1'b0; a8 = 8'h5A; b8 = 8'h77;
    #1 check("hold_f", 64'(f8), 64'h5A);
    edge1();
    check("hold_q", 64'(q8), 64'hA5);
    check("hold_qsel", 64'(qs8), 64'd1);

    // Reset dominates en.
    reset = 1'b1; en8 = 1'b1; sel8 = 1'b1; b8 = 8'hC3;
    edge1();
    check("prio_q", 64'(q8), 64'h3C);
    check("prio_valid", 64'(qv8), 64'd0);
    check("prio_qsel", 64'(qs8), 64'd0);
    check("prio_f", 64'(f8), 64'hC3);
    reset = 1'b0;
    edge1();
    check("post_rst_q", 64'(q8), 64'hC3);
    check("post_rst_valid", 64'(qv8), 64'd1);

    // Mid-operation reset pulse clears the capture.
    en8 = 1'b0; reset = 1'b1; a8 = 8'h42; sel8 = 1'b0;
    edge1();
    check("mid_q", 64'(q8), 64'h3C);
    check("mid_valid", 64'(qv8), 64'd0);
    check("mid_f", 64'(f8), 64'h42);
    reset = 1'b0;

    // Back-to-back captures toggling sel: 00, FF, 00, FF.
    a8 = 8'h00; b8 = 8'hFF; en8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel8 = 1'(i % 2);
      edge1();
      check("b2b_q", 64'(q8), (i % 2 == 1) ? 64'hFF : 64'h00);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 15) == 0);
      en8   = 1'($urandom_range(0, 1));
      sel8  = 1'($urandom_range(0, 1));
      a8    = 8'($urandom);
      b8    = 8'($urandom);
      edge1();
    end

    reset = 1'b0; en8 = 1'b0;
    edge1(); edge1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
